debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Multi-channel, parametrised debouncer for the car-security front panel: door, ignition, keypad and sensor switches.
- Each channel has:
  - a 2-flop synchroniser;
  - a tick-gated stability counter;
  - registered debounced level, rise/fall strobes and a long-hold strobe.
- Sits between raw FPGA pins and the security FSM. The FSM consumes the single-cycle strobes directly.

Parameters:
- CHANNELS, 4, number of independent input channels (1..32).
- STABLE_COUNT, 1000000, consecutive sampled ticks the synchronised input must differ from the debounced level before the level flips (>=2).
- HOLD_COUNT, 0, ticks the debounced level must stay high after a rise before hold_pulse fires. 0 disables hold detection.
- Derived localparams, not overridable:
  - CNT_W = $clog2(STABLE_COUNT+1).
  - HOLD_W = $clog2(HOLD_COUNT+1), minimum 1.

Ports:
- clock, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- tick, input, 1, sample enable. Counters advance only in cycles where tick=1. Tie to 1 for per-clock counting.
- din, input, CHANNELS, raw asynchronous switch inputs.
- level, output, CHANNELS, debounced registered level.
- rise_pulse, output, CHANNELS, one-clock strobe when level goes 0->1.
- fall_pulse, output, CHANNELS, one-clock strobe when level goes 1->0.
- hold_pulse, output, CHANNELS, one-clock strobe when level has been high for HOLD_COUNT ticks.

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-count):
  - sync flops, level, all pulses, stability counters and hold counters clear to 0 immediately.
  - Outputs stay 0 while reset_n=0.
  - After release, a channel whose din=1 behaves as a fresh 0->1 transition.
- Synchroniser: s1 <= din, s2 <= s1 every clock, regardless of tick. All further logic uses s2 only.
- Stability counter, per channel, evaluated at each clock edge:
  - If s2 == level: cnt <= 0, independent of tick. Any bounce back to the current level restarts the count.
  - Else if tick=0: cnt holds.
  - Else if cnt == STABLE_COUNT-1: level <= s2, cnt <= 0, and the matching rise_pulse or fall_pulse is 1 for the following clock cycle.
  - Else: cnt <= cnt+1.
- Latency with tick=1: din changes before edge E1 and stays stable. level changes at edge E1+STABLE_COUNT+1, i.e. the (STABLE_COUNT+2)th edge counting E1 as the first. Strobe is high for exactly that one cycle.
- Strobes: registered, exactly one clock wide regardless of tick. rise_pulse and fall_pulse are never both 1 for a channel. Default 0 in every cycle without an event.
- Hold (HOLD_COUNT>0):
  - hcnt clears to 0 on the edge where level rises and whenever level=0.
  - On each tick edge with level=1 and hcnt < HOLD_COUNT: hcnt <= hcnt+1.
  - hold_pulse is 1 for the single clock following the edge where hcnt reaches HOLD_COUNT.
  - hcnt then saturates, so there is one hold_pulse per press.
  - A fall before HOLD_COUNT gives no hold_pulse.
- HOLD_COUNT=0: hold_pulse tied to 0, no hold counters.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous strobes.
- No counter ever wraps. cnt max is STABLE_COUNT-1; hcnt max is HOLD_COUNT.

Test Plan (bench parameters: CHANNELS=4, STABLE_COUNT=4, HOLD_COUNT=10):
- Reset: reset_n=0 with din=4'b1111 for 5 clocks -> level, rise_pulse, fall_pulse, hold_pulse all 4'b0000. Release -> level=4'b1111 at 6th edge after release, with rise_pulse=4'b1111 for one cycle.
- Clean press: tick=1, din[0] 0->1 before edge 1 -> level[0]=1 after edge 6, rise_pulse[0]=1 during cycle 6 only. din[0] back to 0 -> fall_pulse[0] one cycle, 6 edges later.
- Bounce: din[1] toggles every 2 clocks for 12 clocks, then holds 1 -> level[1] never changes during the bounce, rises 6 edges after the last transition, with no extra strobes.
- Long hold: din[2] held 1 for 30 clocks, tick=1 -> hold_pulse[2] one cycle exactly 10 edges after the level rise, not repeated. A press of only 8 ticks -> no hold_pulse.
- Tick gating: tick=1 every 3rd clock, din[3] 0->1 -> level[3] rises on the 4th tick edge after s2 differs. A glitch of 2 clocks between ticks does not change level.
- Reset mid-operation: assert reset_n when cnt=2 on ch0 and hcnt=5 on ch2 -> outputs clear asynchronously. After release, full STABLE_COUNT and HOLD_COUNT sequences restart from 0.

Source files
------------

// File: rtl/debounce_bank_if.sv
// Switch-debouncer bus: sample enable and raw inputs in, debounced level and event strobes out.
interface debounce_bank_if #(
  parameter int unsigned CHANNELS = 4
);
  logic                tick;
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] hold_pulse;

  modport master (
    output tick, din,
    input  level, rise_pulse, fall_pulse, hold_pulse
  );

  modport slave (
    input  tick, din,
    output level, rise_pulse, fall_pulse, hold_pulse
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: 2-flop synchroniser, tick-gated stability counter,
// registered level with rise/fall strobes and an optional long-hold strobe per channel.
module debounce_bank #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned STABLE_COUNT = 1000000,
  parameter int unsigned HOLD_COUNT   = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  debounce_bank_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(STABLE_COUNT + 1);
  localparam int unsigned HOLD_W = (HOLD_COUNT > 0) ? $clog2(HOLD_COUNT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] hold_q;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  // Synchroniser and stability counters; a bounce back to the current level restarts the count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s2      <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      s1     <= bus.din;
      s2     <= s1;
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (s2[c] == level_q[c]) begin
          cnt[c] <= '0;
        end else if (bus.tick) begin
          if (cnt[c] == CNT_LAST) begin
            level_q[c] <= s2[c];
            cnt[c]     <= '0;
            rise_q[c]  <= s2[c];
            fall_q[c]  <= ~s2[c];
          end else begin
            cnt[c] <= cnt[c] + CNT_W'(1);
          end
        end
      end
    end
  end

  if (HOLD_COUNT > 0) begin : g_hold
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_COUNT);
    logic [HOLD_W-1:0] hcnt [CHANNELS];

    // Hold counter saturates at HOLD_MAX so each press yields at most one strobe
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        hold_q <= '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          hcnt[c] <= '0;
        end
      end else begin
        hold_q <= '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (!level_q[c]) begin
            hcnt[c] <= '0;
          end else if (bus.tick && (hcnt[c] != HOLD_MAX)) begin
            hcnt[c]   <= hcnt[c] + HOLD_W'(1);
            hold_q[c] <= (hcnt[c] == (HOLD_MAX - HOLD_W'(1)));
          end
        end
      end
    end
  end else begin : g_no_hold
    assign hold_q = '0;
  end

  assign bus.level      = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.hold_pulse = hold_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus random traffic, checked against a behavioural model.
module tb_debounce_bank;

  localparam int unsigned CH     = 4;
  localparam int unsigned STABLE = 4;
  localparam int unsigned HOLD   = 10;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  debounce_bank_if #(.CHANNELS(CH)) bus ();

  debounce_bank #(
    .CHANNELS    (CH),
    .STABLE_COUNT(STABLE),
    .HOLD_COUNT  (HOLD)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit gate     = 1'b0;
  int cyc      = 0;

  // Reference model: a level flips once the synchronised input has disagreed with it
  // for STABLE consecutive tick samples; hold fires when a high level has seen HOLD ticks.
  bit [CH-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_hold;
  int          m_run  [CH];
  int          m_held [CH];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_rise = '0; m_fall = '0; m_hold = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[c]  = 0;
        m_held[c] = 0;
      end
    end else begin
      m_rise = '0; m_fall = '0; m_hold = '0;
      for (int c = 0; c < CH; c++) begin
        if (!m_lvl[c]) m_held[c] = 0;
        else if (bus.tick && m_held[c] < HOLD) begin
          m_held[c] = m_held[c] + 1;
          m_hold[c] = (m_held[c] == HOLD);
        end
        if (m_s2[c] == m_lvl[c]) m_run[c] = 0;
        else if (bus.tick) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == STABLE) begin
            m_run[c] = 0;
            m_lvl[c] = m_s2[c];
            if (m_s2[c]) m_rise[c] = 1'b1;
            else         m_fall[c] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.din;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare against the model on the falling edge, then set tick for the next edge
  task automatic adv();
    @(negedge clock);
    check("level", 32'(bus.level), 32'(m_lvl));
    check("rise",  32'(bus.rise_pulse), 32'(m_rise));
    check("fall",  32'(bus.fall_pulse), 32'(m_fall));
    check("hold",  32'(bus.hold_pulse), 32'(m_hold));
    check("excl",  32'(bus.rise_pulse & bus.fall_pulse), 32'd0);
    cyc++;
    bus.tick = gate ? ((cyc % 3) == 0) : 1'b1;
  endtask

  // Edges until the selected strobe/level bit is seen (0 rise, 1 fall, 2 hold, 3 level); -1 on timeout
  task automatic wait_bit(input int sel, input int ch, output int n);
    logic [CH-1:0] v;
    n = -1;
    for (int k = 1; k <= 60; k++) begin
      adv();
      case (sel)
        0:       v = bus.rise_pulse;
        1:       v = bus.fall_pulse;
        2:       v = bus.hold_pulse;
        default: v = bus.level;
      endcase
      if (v[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int hc;
    int ticks;
    int k;
    bit hit;
    logic t;
    logic [CH-1:0] flips;

    reset_n  = 1'b0;
    bus.din  = 4'b1111;
    bus.tick = 1'b1;

    repeat (5) begin
      adv();
      check("rst_level", 32'(bus.level), 32'd0);
      check("rst_pulses", 32'(bus.rise_pulse | bus.fall_pulse | bus.hold_pulse), 32'd0);
    end

    reset_n = 1'b1;
    wait_bit(0, 0, n);
    check("rel_rise_lat", n, 32'd6);
    check("rel_rise_all", 32'(bus.rise_pulse), 32'hf);
    wait_bit(2, 0, n);
    check("rel_hold_lat", n, 32'd10);
    check("rel_hold_all", 32'(bus.hold_pulse), 32'hf);
    bus.din = 4'b0000;
    wait_bit(1, 0, n);
    check("rel_fall_lat", n, 32'd6);

    // Clean press on channel 0
    bus.din = 4'b0001;
    wait_bit(0, 0, n);
    check("press_rise_lat", n, 32'd6);
    check("press_level", 32'(bus.level), 32'h1);
    bus.din = 4'b0000;
    wait_bit(1, 0, n);
    check("press_fall_lat", n, 32'd6);

    // Bounce on channel 1: 2-clock toggles never reach the stability threshold
    for (int i = 0; i < 12; i++) begin
      bus.din[1] = (((i / 2) % 2) == 0);
      adv();
      check("bounce_level", 32'(bus.level[1]), 32'd0);
    end
    bus.din[1] = 1'b1;
    wait_bit(0, 1, n);
    check("bounce_rise_lat", n, 32'd6);
    bus.din[1] = 1'b0;
    wait_bit(1, 1, n);
    check("bounce_fall_lat", n, 32'd6);

    // Long hold on channel 2, then a short press that must not produce a hold strobe
    bus.din[2] = 1'b1;
    wait_bit(0, 2, n);
    check("long_rise_lat", n, 32'd6);
    wait_bit(2, 2, n);
    check("long_hold_lat", n, 32'd10);
    hc = 0;
    repeat (20) begin
      adv();
      if (bus.hold_pulse[2]) hc++;
    end
    check("long_hold_once", hc, 32'd0);
    bus.din[2] = 1'b0;
    wait_bit(1, 2, n);
    check("long_fall_lat", n, 32'd6);
    bus.din[2] = 1'b1;
    wait_bit(0, 2, n);
    check("short_rise_lat", n, 32'd6);
    adv();
    adv();
    bus.din[2] = 1'b0;
    hc = 0;
    repeat (20) begin
      adv();
      if (bus.hold_pulse[2]) hc++;
    end
    check("short_no_hold", hc, 32'd0);
    check("short_level", 32'(bus.level[2]), 32'd0);

    // Tick gating on channel 3: rise on the 4th tick edge after the synchronised input differs
    gate = 1'b1;
    repeat (3) adv();
    bus.din[3] = 1'b1;
    ticks = 0;
    k     = 0;
    hit   = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      t = bus.tick;
      adv();
      k++;
      if (k >= 3 && t) ticks++;
      if (bus.rise_pulse[3]) hit = 1'b1;
    end
    check("gate_hit", 32'(hit), 32'd1);
    check("gate_ticks", ticks, 32'd4);
    bus.din[3] = 1'b0;
    adv();
    adv();
    bus.din[3] = 1'b1;
    repeat (15) begin
      adv();
      check("glitch_level", 32'(bus.level[3]), 32'd1);
    end
    gate = 1'b0;
    adv();
    bus.din[3] = 1'b0;
    wait_bit(1, 3, n);
    check("gate_fall_lat", n, 32'd6);

    // Asynchronous reset with ch0 mid-count and ch2 mid-hold, then full restart
    bus.din[2] = 1'b1;
    wait_bit(0, 2, n);
    check("mid_rise_lat", n, 32'd6);
    adv();
    bus.din[0] = 1'b1;
    repeat (4) adv();
    #2 reset_n = 1'b0;
    #1;
    check("async_level", 32'(bus.level), 32'd0);
    check("async_rise", 32'(bus.rise_pulse), 32'd0);
    check("async_fall", 32'(bus.fall_pulse), 32'd0);
    check("async_hold", 32'(bus.hold_pulse), 32'd0);
    adv();
    adv();
    reset_n = 1'b1;
    wait_bit(0, 0, n);
    check("restart_rise_lat", n, 32'd6);
    check("restart_rise", 32'(bus.rise_pulse), 32'h5);
    wait_bit(2, 2, n);
    check("restart_hold_lat", n, 32'd10);
    bus.din = 4'b0000;
    wait_bit(1, 0, n);
    check("restart_fall_lat", n, 32'd6);

    // Random traffic with slow-changing inputs and random tick gating
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) flips[c] = ($urandom_range(0, 5) == 0);
      bus.din = bus.din ^ flips;
      adv();
      bus.tick = ($urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
